// File: rtl/mouse_motion_tracker.sv
// Per-frame cursor history with windowed velocity, button press latches and a CPU read port.
// Optional SMOOTH_EN: velocity is averaged with its previous value instead of written raw.
module mouse_motion_tracker #(
  parameter int WINDOW  = 4,
  parameter int HIST_AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [8:0] pos_x,
  input  logic [8:0] pos_y,
  input  logic [2:0] buttons,
  input  logic       io_cs,
  input  logic       rd,
  input  logic [1:0] addr,
  output logic [7:0] data,
  output logic       vel_valid
);

  localparam int DEPTH = 2 ** HIST_AW;
  localparam logic [4:0]         FILL_MAX = 5'(WINDOW + 1);
  localparam logic [4:0]         FILL_WIN = 5'(WINDOW);
  localparam logic [HIST_AW-1:0] WIN_OFS  = HIST_AW'(WINDOW);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SAMPLE = 2'd1;
  localparam logic [1:0] DIFF   = 2'd2;
  localparam logic [1:0] UPDATE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [HIST_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [4:0]         fill_q, fill_d;
  logic signed [7:0]  vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic               vel_valid_q, vel_valid_d;
  logic               overrun_q, overrun_d;
  logic [2:0]         press_q, press_d;
  logic [2:0]         btn_prev_q;
  logic [7:0]         sample_cnt_q, sample_cnt_d;
  logic [8:0]         now_x_q, now_y_q, old_x_q, old_y_q;
  logic signed [9:0]  dx_q, dy_q;
  logic [17:0]        ring_q [DEPTH];
  logic [17:0]        old_ent;

  logic              status_rd;
  logic              ovr_evt;
  logic              win_full;
  logic signed [7:0] sat_x, sat_y, new_x, new_y;

  function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
    if (v > 10'sd127) return 8'sh7f;
    else if (v < -10'sd128) return 8'sh80;
    else return v[7:0];
  endfunction

  function automatic logic signed [7:0] avg8(input logic signed [7:0] a,
                                             input logic signed [7:0] b);
    logic signed [8:0] s;
    s = {a[7], a} + {b[7], b};
    return s[8:1];
  endfunction

  // History ring is deliberately not reset; fill_q decides when its contents are trusted.
  always_ff @(posedge clk) begin
    if (state_q == SAMPLE) ring_q[wr_ptr_q] <= {pos_x, pos_y};
  end

  assign old_ent   = ring_q[wr_ptr_q - WIN_OFS];
  assign status_rd = io_cs & rd & (addr == 2'b00);
  assign ovr_evt   = frame_tick & (state_q != IDLE);
  assign win_full  = (fill_q >= FILL_WIN);
  assign sat_x     = sat8(dx_q);
  assign sat_y     = sat8(dy_q);

`ifdef SMOOTH_EN
  assign new_x = vel_valid_q ? avg8(vel_x_q, sat_x) : avg8(8'sd0, sat_x);
  assign new_y = vel_valid_q ? avg8(vel_y_q, sat_y) : avg8(8'sd0, sat_y);
`else
  assign new_x = sat_x;
  assign new_y = sat_y;
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    vel_x_d      = vel_x_q;
    vel_y_d      = vel_y_q;
    vel_valid_d  = vel_valid_q;
    sample_cnt_d = sample_cnt_q;
    case (state_q)
      IDLE:   if (frame_tick) state_d = SAMPLE;
      SAMPLE: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d  = DIFF;
      end
      DIFF:   state_d = UPDATE;
      default: begin
        vel_valid_d  = win_full;
        vel_x_d      = win_full ? new_x : 8'sd0;
        vel_y_d      = win_full ? new_y : 8'sd0;
        sample_cnt_d = sample_cnt_q + 8'd1;
        if (fill_q < FILL_MAX) fill_d = fill_q + 5'd1;
        state_d = IDLE;
      end
    endcase
    // A fresh event in the same cycle as a status read must survive the clear.
    press_d   = (press_q & {3{~status_rd}}) | (buttons & ~btn_prev_q);
    overrun_d = (overrun_q & ~status_rd) | ovr_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      vel_x_q      <= '0;
      vel_y_q      <= '0;
      vel_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      press_q      <= '0;
      btn_prev_q   <= '0;
      sample_cnt_q <= '0;
      now_x_q      <= '0;
      now_y_q      <= '0;
      old_x_q      <= '0;
      old_y_q      <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      vel_x_q      <= vel_x_d;
      vel_y_q      <= vel_y_d;
      vel_valid_q  <= vel_valid_d;
      overrun_q    <= overrun_d;
      press_q      <= press_d;
      btn_prev_q   <= buttons;
      sample_cnt_q <= sample_cnt_d;
      if (state_q == SAMPLE) begin
        now_x_q <= pos_x;
        now_y_q <= pos_y;
        old_x_q <= old_ent[17:9];
        old_y_q <= old_ent[8:0];
      end
      if (state_q == DIFF) begin
        dx_q <= $signed({1'b0, now_x_q}) - $signed({1'b0, old_x_q});
        dy_q <= $signed({1'b0, now_y_q}) - $signed({1'b0, old_y_q});
      end
    end
  end

  always_comb begin
    data = 8'd0;
    if (io_cs) begin
      case (addr)
        2'b00:   data = {vel_valid_q, overrun_q, press_q, buttons};
        2'b01:   data = vel_x_q;
        2'b10:   data = vel_y_q;
        default: data = sample_cnt_q;
      endcase
    end
  end

  assign vel_valid = vel_valid_q;

endmodule

// File: tb/tb_mouse_motion_tracker.sv
// Directed bench for mouse_motion_tracker (WINDOW=4, default build).
module tb_mouse_motion_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [8:0] pos_x = '0;
  logic [8:0] pos_y = '0;
  logic [2:0] buttons = '0;
  logic       io_cs = 1'b0;
  logic       rd = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] data;
  logic       vel_valid;

  int total = 0;
  int bad   = 0;

  mouse_motion_tracker #(.WINDOW(4), .HIST_AW(4)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y),
    .buttons(buttons), .io_cs(io_cs), .rd(rd), .addr(addr), .data(data),
    .vel_valid(vel_valid)
  );

  always #5 clk = ~clk;

  // One frame: pulse tick, then wait until the UPDATE edge has passed.
  task automatic tick(input logic [8:0] x, input logic [8:0] y);
    pos_x = x; pos_y = y; frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    io_cs = 1'b1; rd = 1'b0; addr = a;
    #1 d = data;
    io_cs = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
    io_cs = 1'b1; rd = 1'b1; addr = a;
    #1 d = data;
    @(posedge clk); #1 io_cs = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    for (int a = 0; a < 4; a++) begin
      peek(2'(a), d);
      total++;
      if (d !== 8'd0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=00", a, d); end
    end
    total++;
    if (vel_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", vel_valid); end
    io_cs = 1'b1; #1;
    total++;
    if (data === 8'd0) ; else begin bad++; $display("FAIL reset_cs got=%h exp=00", data); end
    io_cs = 1'b0; #1;
    total++;
    if (data !== 8'd0) begin bad++; $display("FAIL cs_low got=%h exp=00", data); end
  endtask

  task automatic test_velocity;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      tick(9'(100 + 10*i), 9'(300 - 10*i));
      peek(2'b01, d);
      total++;
      if (d !== 8'd0) begin bad++; $display("FAIL vel_fill%0d got=%h exp=00", i, d); end
      total++;
      if (vel_valid !== 1'b0) begin bad++; $display("FAIL valid_fill%0d got=%b exp=0", i, vel_valid); end
    end
    tick(9'd140, 9'd260);
    peek(2'b01, d);
    total++;
    if (d !== 8'd40) begin bad++; $display("FAIL vel_x got=%h exp=28", d); end
    peek(2'b10, d);
    total++;
    if (d !== 8'hd8) begin bad++; $display("FAIL vel_y got=%h exp=d8", d); end
    total++;
    if (vel_valid !== 1'b1) begin bad++; $display("FAIL valid5 got=%b exp=1", vel_valid); end
    peek(2'b11, d);
    total++;
    if (d !== 8'd5) begin bad++; $display("FAIL cnt5 got=%h exp=05", d); end
  endtask

  task automatic test_saturation;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) tick(9'd0, 9'd50);
    tick(9'd409, 9'd50);
    peek(2'b01, d);
    total++;
    if (d !== 8'h7f) begin bad++; $display("FAIL sat_pos got=%h exp=7f", d); end
    for (int i = 0; i < 4; i++) tick(9'd409, 9'd50);
    tick(9'd0, 9'd50);
    peek(2'b01, d);
    total++;
    if (d !== 8'h80) begin bad++; $display("FAIL sat_neg got=%h exp=80", d); end
    total++;
    if (vel_valid !== 1'b1) begin bad++; $display("FAIL sat_valid got=%b exp=1", vel_valid); end
  endtask

  task automatic test_buttons;
    logic [7:0] d;
    buttons = 3'b001; repeat (2) @(posedge clk); #1;
    buttons = 3'b000; repeat (2) @(posedge clk); #1;
    rd_reg(2'b01, d);
    rd_reg(2'b00, d);
    total++;
    if (d !== 8'h88) begin bad++; $display("FAIL press_status got=%h exp=88", d); end
    peek(2'b00, d);
    total++;
    if (d[5:3] !== 3'b000) begin bad++; $display("FAIL press_clear got=%b exp=000", d[5:3]); end
    buttons = 3'b001;
    rd_reg(2'b00, d);
    peek(2'b00, d);
    total++;
    if (d[5:3] !== 3'b001) begin bad++; $display("FAIL press_coincident got=%b exp=001", d[5:3]); end
    total++;
    if (d[2:0] !== 3'b001) begin bad++; $display("FAIL live_buttons got=%b exp=001", d[2:0]); end
    buttons = 3'b000;
    rd_reg(2'b00, d);
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (4) @(posedge clk); #1;
    peek(2'b11, d);
    total++;
    if (d !== 8'd16) begin bad++; $display("FAIL overrun_cnt got=%0d exp=16", d); end
    peek(2'b00, d);
    total++;
    if (d[6] !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", d[6]); end
    rd_reg(2'b00, d);
    peek(2'b00, d);
    total++;
    if (d[6] !== 1'b0) begin bad++; $display("FAIL overrun_clear got=%b exp=0", d[6]); end
  endtask

  task automatic test_mid_reset;
    logic [7:0] d;
    pos_x = 9'd300; frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    for (int a = 0; a < 4; a++) begin
      peek(2'(a), d);
      total++;
      if (d !== 8'd0) begin bad++; $display("FAIL midrst_reg%0d got=%h exp=00", a, d); end
    end
    total++;
    if (vel_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", vel_valid); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) tick(9'(200 + 10*i), 9'd20);
    total++;
    if (vel_valid !== 1'b0) begin bad++; $display("FAIL refill_valid got=%b exp=0", vel_valid); end
    tick(9'd240, 9'd20);
    peek(2'b01, d);
    total++;
    if (d !== 8'd40) begin bad++; $display("FAIL refill_vel got=%h exp=28", d); end
    peek(2'b11, d);
    total++;
    if (d !== 8'd5) begin bad++; $display("FAIL refill_cnt got=%0d exp=5", d); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_velocity();
    test_saturation();
    test_buttons();
    test_overrun();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
